// File: rtl/ledger_writer.sv
// Packs a raster stream of 4-bit grey pixels into 32-bit words and writes them
// to frame RAM at row*COLS + column, pulsing frame_done after the last word.
module ledger_writer #(
    parameter int ROWS = 480,
    parameter int COLS = 80
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [3:0]  pix_data,
    output logic        pix_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [15:0]   ROW_STEP = 16'(COLS);

    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      nib_reg;
    logic [CW-1:0]   col_reg;
    logic [RW-1:0]   row_reg;
    logic [15:0]     row_base_reg;
    logic [31:0]     pack_reg;
    logic            xfer;
    logic            last_col;
    logic            last_row;

    assign xfer     = (state_reg == PACK) && pix_valid;
    assign last_col = (col_reg == LAST_COL);
    assign last_row = (row_reg == LAST_ROW);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = PACK;
            PACK:    if (xfer && nib_reg == 3'd7) state_next = WRITE;
            WRITE:   state_next = (last_col && last_row) ? DONE : PACK;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are flops loaded from the next state so they never glitch.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg  <= IDLE;
            pix_ready  <= 1'b0;
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pix_ready  <= (state_next == PACK);
            wr_en      <= (state_next == WRITE);
            busy       <= (state_next != IDLE);
            frame_done <= (state_next == DONE);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nib_reg      <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            row_base_reg <= '0;
            pack_reg     <= '0;
            wr_data      <= '0;
            wr_addr      <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        nib_reg      <= '0;
                        col_reg      <= '0;
                        row_reg      <= '0;
                        row_base_reg <= '0;
                    end
                end
                PACK: begin
                    if (xfer) begin
                        pack_reg[{nib_reg, 2'b00} +: 4] <= pix_data;
                        nib_reg <= nib_reg + 3'd1;
                        // Word is complete: latch it together with its address.
                        if (nib_reg == 3'd7) begin
                            wr_data <= {pix_data, pack_reg[27:0]};
                            wr_addr <= row_base_reg + 16'(col_reg);
                        end
                    end
                end
                WRITE: begin
                    if (last_col) begin
                        col_reg <= '0;
                        if (last_row) begin
                            row_reg      <= '0;
                            row_base_reg <= '0;
                        end else begin
                            row_reg      <= row_reg + 1'b1;
                            row_base_reg <= row_base_reg + ROW_STEP;
                        end
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ledger_writer.sv
// Drives a default-size and a 2x3 ledger_writer with the same stimulus and
// checks both against a pixel-count model every cycle plus directed literals.
module tb_ledger_writer;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic start = 1'b0;
    logic pix_valid = 1'b0;
    logic [3:0] pix_data = 4'h0;

    logic [1:0]        pr, we, bz, fd;
    logic [1:0][15:0]  wa;
    logic [1:0][31:0]  wd;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ledger_writer dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pr[0]), .wr_en(we[0]), .wr_addr(wa[0]),
        .wr_data(wd[0]), .busy(bz[0]), .frame_done(fd[0])
    );

    ledger_writer #(.ROWS(2), .COLS(3)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pr[1]), .wr_en(we[1]), .wr_addr(wa[1]),
        .wr_data(wd[1]), .busy(bz[1]), .frame_done(fd[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: a frame is just a count of accepted pixels; every 8th pixel is
    // word number px/8-1 and is written on the following cycle.
    typedef struct {
        bit          act;
        bit          wr;
        bit          done;
        int          px;
        int          words;
        logic [31:0] acc;
        logic [31:0] data;
        logic [15:0] addr;
    } model_t;

    model_t m [2];
    int total [2] = '{480 * 80, 2 * 3};

    function automatic model_t zero_model();
        model_t z;
        z.act = 0; z.wr = 0; z.done = 0; z.px = 0; z.words = 0;
        z.acc = '0; z.data = '0; z.addr = '0;
        return z;
    endfunction

    function automatic model_t step(model_t s, int tot, logic st, logic v, logic [3:0] p);
        model_t n = s;
        int k;
        if (s.done) begin
            n.done = 0;
            n.act  = 0;
        end else if (s.wr) begin
            n.wr = 0;
            n.words = s.words + 1;
            if (n.words == tot) n.done = 1;
        end else if (s.act) begin
            if (v) begin
                k = s.px % 8;
                if (k == 0) n.acc = '0;
                n.acc = n.acc | (32'(p) << (4 * k));
                n.px = s.px + 1;
                if (n.px % 8 == 0) begin
                    n.wr   = 1;
                    n.data = n.acc;
                    n.addr = 16'(n.px / 8 - 1);
                end
            end
        end else if (st) begin
            n.act = 1;
            n.px = 0;
            n.words = 0;
        end
        return n;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!Reset_n) m[d] <= zero_model();
            else          m[d] <= step(m[d], total[d], start, pix_valid, pix_data);
        end
    end

    int wr_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    logic [15:0] aq0 [$];
    logic [15:0] aq1 [$];

    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cyc pix_ready d%0d", d), 32'(pr[d]), 32'(m[d].act && !m[d].wr && !m[d].done));
            chk($sformatf("cyc wr_en d%0d", d), 32'(we[d]), 32'(m[d].wr));
            chk($sformatf("cyc busy d%0d", d), 32'(bz[d]), 32'(m[d].act));
            chk($sformatf("cyc frame_done d%0d", d), 32'(fd[d]), 32'(m[d].done));
            chk($sformatf("cyc wr_addr d%0d", d), 32'(wa[d]), 32'(m[d].addr));
            chk($sformatf("cyc wr_data d%0d", d), wd[d], m[d].data);
            if (we[d]) wr_cnt[d]++;
            if (fd[d]) done_cnt[d]++;
        end
        if (we[0]) aq0.push_back(wa[0]);
        if (we[1]) aq1.push_back(wa[1]);
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] p);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = p;
        while (!pr[0] && n < 20) begin
            tick();
            n++;
        end
        if (!pr[0]) chk("ready_timeout", 32'(pr[0]), 32'd1);
        tick();
        pix_valid = 1'b0;
    endtask

    initial begin
        int w0, d1, xfers, acc_n, budget;
        logic [3:0] v;

        // Reset state
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("rst wr_en", 32'(we[d]), 0);
            chk("rst pix_ready", 32'(pr[d]), 0);
            chk("rst busy", 32'(bz[d]), 0);
            chk("rst frame_done", 32'(fd[d]), 0);
            chk("rst wr_addr", 32'(wa[d]), 0);
            chk("rst wr_data", wd[d], 0);
        end
        tick();
        Reset_n = 1'b1;
        tick();

        // Single word 1..8
        pulse_start();
        for (int i = 1; i <= 8; i++) send(4'(i));
        chk("single wr_en", 32'(we[0]), 1);
        chk("single wr_addr", 32'(wa[0]), 0);
        chk("single wr_data", wd[0], 32'h87654321);
        chk("single pix_ready", 32'(pr[0]), 0);
        tick();

        // Backpressure gaps
        do_reset();
        w0 = wr_cnt[0];
        xfers = 0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1; pix_data = 4'hF;
            if (pr[0]) xfers++;
            tick();
            pix_valid = 1'b0;
            tick();
        end
        tick(); tick();
        chk("gaps transfers", 32'(xfers), 8);
        chk("gaps writes", 32'(wr_cnt[0] - w0), 1);
        chk("gaps wr_data", wd[0], 32'hFFFFFFFF);

        // Reset mid-word
        do_reset();
        w0 = wr_cnt[0];
        pulse_start();
        for (int i = 0; i < 5; i++) send(4'hA);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick(); tick();
        chk("midrst no write", 32'(wr_cnt[0] - w0), 0);
        chk("midrst busy", 32'(bz[0]), 0);
        pulse_start();
        for (int i = 8; i >= 1; i--) send(4'(i));
        chk("midrst wr_en", 32'(we[0]), 1);
        chk("midrst wr_addr", 32'(wa[0]), 0);
        chk("midrst wr_data", wd[0], 32'h12345678);

        // Spurious start during PACK
        do_reset();
        pulse_start();
        for (int i = 3; i <= 5; i++) send(4'(i));
        pulse_start();
        for (int i = 6; i <= 10; i++) send(4'(i));
        chk("spurious wr_en", 32'(we[0]), 1);
        chk("spurious wr_addr", 32'(wa[0]), 0);
        chk("spurious wr_data", wd[0], 32'hA9876543);

        // Full 2x3 frame on dut_b
        do_reset();
        aq1.delete();
        d1 = done_cnt[1];
        pulse_start();
        for (int i = 0; i < 48; i++) begin
            v = 4'($urandom);
            send(v);
        end
        tick(); tick(); tick();
        chk("frame writes", 32'(aq1.size()), 6);
        for (int i = 0; i < aq1.size() && i < 6; i++)
            chk($sformatf("frame addr %0d", i), 32'(aq1[i]), 32'(i));
        chk("frame done pulses", 32'(done_cnt[1] - d1), 1);
        chk("frame busy after", 32'(bz[1]), 0);

        // Row wrap on dut_a with random gaps and stray starts
        do_reset();
        aq0.delete();
        pulse_start();
        acc_n = 0;
        budget = 0;
        while (acc_n < 81 * 8 && budget < 4000) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_data  = 4'($urandom);
            start     = ($urandom_range(0, 49) == 0);
            if (pix_valid && pr[0]) acc_n++;
            tick();
            budget++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        chk("wrap budget", 32'(acc_n), 32'(81 * 8));
        tick(); tick(); tick();
        chk("wrap writes", 32'(aq0.size()), 81);
        if (aq0.size() >= 81) begin
            chk("wrap addr 79", 32'(aq0[79]), 79);
            chk("wrap addr 80", 32'(aq0[80]), 80);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ledger_writer.md
LEDGER_WRITER -- requirements
Module: ledger_writer

Interface
REQ-001 Parameter ROWS, default 480, frame height in rows.
REQ-002 Parameter COLS, default 80, packed 32-bit words per row (640 pixels / 8).
REQ-003 Port Clk, input, 1, system clock; all state changes on rising edge.
REQ-004 Port Reset_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-005 Port start, input, 1, single-cycle pulse that begins a frame capture; sampled only in IDLE.
REQ-006 Port pix_valid, input, 1, pix_data holds a valid pixel.
REQ-007 Port pix_data, input, 4, grey-level pixel, raster order (left to right, top to bottom).
REQ-008 Port pix_ready, output, 1, block accepts pix_data this cycle.
REQ-009 Port wr_en, output, 1, frame-RAM write strobe.
REQ-010 Port wr_addr, output, 16, word address = row*COLS + word column.
REQ-011 Port wr_data, output, 32, packed word of 8 pixels.
REQ-012 Port busy, output, 1, high in every state except IDLE.
REQ-013 Port frame_done, output, 1, single-cycle pulse after the last word of the frame is written.

Function
REQ-014 States: IDLE, PACK, WRITE, DONE. Encoding is free.
REQ-015 IDLE: pix_ready=0. start=1 moves to PACK and clears the row, column, and nibble counters.
REQ-016 PACK: pix_ready=1. A transfer occurs when pix_valid=1 and pix_ready=1. Nothing changes when pix_valid=0.
REQ-017 Nibble packing: pixel k of a word (k=0..7, k=0 is leftmost) goes to wr_data[4k+3:4k], so pixel 0 occupies bits [3:0].
REQ-018 A transfer with nibble count <7 stores the nibble and increments the count.
REQ-019 A transfer with nibble count =7 stores the nibble, resets the count to 0, and moves to WRITE.
REQ-020 WRITE lasts exactly one cycle with wr_en=1, pix_ready=0, and the wr_data/wr_addr of the completed word.
REQ-021 Latency: wr_en asserts on the cycle after the 8th accepted pixel of a word.
REQ-022 After WRITE, the word column increments. At COLS-1 it wraps to 0 and the row increments.
REQ-023 After WRITE, if row=ROWS-1 and column=COLS-1 before the increment, go to DONE; otherwise go to PACK.
REQ-024 DONE lasts one cycle with frame_done=1, then returns to IDLE. Row and column are 0 on IDLE entry.
REQ-025 wr_addr is computed with 16-bit arithmetic. The maximum is ROWS*COLS-1 = 38399; no overflow is permitted at the defaults.
REQ-026 wr_en, frame_done, and pix_ready are registered state decodes, not combinational functions of pix_valid.
REQ-027 start asserted outside IDLE is ignored and does not restart the frame.
REQ-028 wr_data and wr_addr are don't-care when wr_en=0, but shall hold their last value (no toggling).

Reset
REQ-029 On Reset_n=0, immediately and independent of Clk:
  - state goes to IDLE;
  - all counters and wr_data are cleared to 0;
  - pix_ready, wr_en, busy, and frame_done are 0;
  - wr_addr is 0.
REQ-030 Reset asserted mid-frame discards the partial word with no write. Capture resumes only on a new start after release.
REQ-031 Outputs shall not glitch high during or on release of reset.

Verification
REQ-032 Single word: start, then 8 consecutive valid pixels 1,2,...,8 -> next cycle wr_en=1, wr_addr=0, wr_data=0x87654321; pix_ready=0 that cycle.
REQ-033 Backpressure gaps: start, then pixels 0xF x8 with pix_valid toggling 1/0 -> exactly one wr_en, wr_data=0xFFFFFFFF, 8 accepted transfers counted by the bench.
REQ-034 Row wrap: stream 80 words -> last wr_addr=79; the next word writes wr_addr=80 (row 1, column 0).
REQ-035 Full frame (ROWS=2, COLS=3 override): 48 pixels -> 6 writes with addresses 0..5, then frame_done pulses once for one cycle, then busy=0.
REQ-036 Reset mid-word: start, 5 pixels, Reset_n=0 for 1 cycle -> no wr_en; after release, start plus 8 pixels writes wr_addr=0 with only the new nibbles.
REQ-037 Spurious start: a start pulse during PACK after 3 pixels -> ignored; counters continue and the first write is still wr_addr=0 after 8 pixels total.
